// File: rtl/bcd_operand_encoder.sv
// BCD operand encoder: converts a packed BCD operand to unsigned binary using a
// multi-cycle reverse double-dabble (one bit per clock) with a start/busy/done handshake.
// Flags non-decimal digits and results that do not fit in OUT_W bits.
module bcd_operand_encoder #(
   parameter int unsigned N_DIGITS = 10,
   parameter int unsigned OUT_W    = 30
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [4*N_DIGITS-1:0] bcd_in,
   output logic                  busy,
   output logic                  done,
   output logic [OUT_W-1:0]      value,
   output logic                  invalid,
   output logic                  overflow
);

   localparam int unsigned AW = 4 * N_DIGITS;
   localparam int unsigned CW = (AW > 1) ? $clog2(AW) : 1;

   typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

   state_e            state_q;
   logic [AW-1:0]     b_q;
   logic [AW-1:0]     a_q;
   logic [CW-1:0]     cnt_q;

   logic              digit_bad;
   logic [AW-1:0]     b_shift;
   logic [AW-1:0]     b_adj;
   logic [AW-1:0]     a_shift;
   logic              last_shift;
   logic              ovf_next;
   logic [OUT_W-1:0]  val_next;

   // Detect any nibble of the incoming operand that is not a decimal digit.
   always_comb begin
      digit_bad = 1'b0;
      for (int i = 0; i < N_DIGITS; i++) begin
         if (bcd_in[4*i +: 4] > 4'd9) digit_bad = 1'b1;
      end
   end

   // One reverse double-dabble step: shift {B,A} right, then correct every BCD nibble >= 8.
   always_comb begin
      b_shift = {1'b0, b_q[AW-1:1]};
      a_shift = {b_q[0], a_q[AW-1:1]};
      b_adj   = b_shift;
      for (int i = 0; i < N_DIGITS; i++) begin
         if (b_shift[4*i +: 4] >= 4'd8) b_adj[4*i +: 4] = b_shift[4*i +: 4] - 4'd3;
      end
   end

   assign last_shift = (cnt_q == CW'(AW - 1));

   // Result formatting uses the post-shift accumulator so the final step and done coincide.
   if (OUT_W < AW) begin : g_ovf
      assign ovf_next = |a_shift[AW-1:OUT_W];
      assign val_next = ovf_next ? {OUT_W{1'b1}} : a_shift[OUT_W-1:0];
   end else begin : g_no_ovf
      assign ovf_next = 1'b0;
      assign val_next = OUT_W'(a_shift);
   end

   // Conversion FSM with registered handshake and result outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         b_q      <= '0;
         a_q      <= '0;
         cnt_q    <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         value    <= '0;
         invalid  <= 1'b0;
         overflow <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state_q)
            StIdle, StDone: begin
               state_q <= StIdle;
               busy    <= 1'b0;
               if (start) begin
                  if (digit_bad) begin
                     // Rejected operand reports immediately without entering SHIFT.
                     state_q  <= StDone;
                     done     <= 1'b1;
                     invalid  <= 1'b1;
                     overflow <= 1'b0;
                     value    <= '0;
                  end else begin
                     state_q <= StShift;
                     busy    <= 1'b1;
                     b_q     <= bcd_in;
                     a_q     <= '0;
                     cnt_q   <= '0;
                  end
               end
            end
            StShift: begin
               b_q   <= b_adj;
               a_q   <= a_shift;
               cnt_q <= cnt_q + 1'b1;
               if (last_shift) begin
                  state_q  <= StDone;
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  value    <= val_next;
                  overflow <= ovf_next;
                  invalid  <= 1'b0;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_bcd_operand_encoder.sv
// Self-checking bench for bcd_operand_encoder: a cycle model predicts acceptance, latency,
// busy and the held results; expected results queue up at acceptance and are checked at done.
module tb_bcd_operand_encoder;

   localparam int unsigned N_DIGITS = 10;
   localparam int unsigned OUT_W    = 30;
   localparam int unsigned AW       = 4 * N_DIGITS;

   logic              clk;
   logic              rst_n;
   logic              start;
   logic [AW-1:0]     bcd_in;
   logic              busy;
   logic              done;
   logic [OUT_W-1:0]  value;
   logic              invalid;
   logic              overflow;

   bcd_operand_encoder #(
      .N_DIGITS (N_DIGITS),
      .OUT_W    (OUT_W)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .bcd_in   (bcd_in),
      .busy     (busy),
      .done     (done),
      .value    (value),
      .invalid  (invalid),
      .overflow (overflow)
   );

   typedef struct {
      logic [OUT_W-1:0] v;
      logic             inv;
      logic             ovf;
      int unsigned      due;
   } exp_t;

   exp_t             exp_q[$];
   int unsigned      cyc;
   int unsigned      mdl_cnt;
   logic [OUT_W-1:0] held_v;
   logic             held_inv;
   logic             held_ovf;
   int               checks;
   int               errors;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   // Independent decimal reference: sum of digits times powers of ten.
   function automatic exp_t ref_conv(input logic [AW-1:0] bcd, input int unsigned due);
      exp_t            e;
      longint unsigned acc;
      logic [3:0]      d;
      acc   = 0;
      e.inv = 1'b0;
      for (int i = N_DIGITS - 1; i >= 0; i--) begin
         d = bcd[4*i +: 4];
         if (d > 4'd9) e.inv = 1'b1;
         acc = acc * 10 + longint'(d);
      end
      e.due = due;
      if (e.inv) begin
         e.v   = '0;
         e.ovf = 1'b0;
      end else if (acc > ((64'd1 << OUT_W) - 1)) begin
         e.v   = '1;
         e.ovf = 1'b1;
      end else begin
         e.v   = acc[OUT_W-1:0];
         e.ovf = 1'b0;
      end
      return e;
   endfunction

   // Cycle model at each rising edge, then output checks 1 time unit later.
   always begin
      exp_t e;
      logic exp_done;
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
         exp_q.delete();
         mdl_cnt  = 0;
         held_v   = '0;
         held_inv = 1'b0;
         held_ovf = 1'b0;
      end else if (mdl_cnt > 0) begin
         mdl_cnt--;
      end else if (start) begin
         e = ref_conv(bcd_in, cyc);
         if (!e.inv) begin
            e.due   = cyc + AW;
            mdl_cnt = AW;
         end
         exp_q.push_back(e);
      end
      #1;
      if (rst_n) begin
         while (exp_q.size() > 0 && exp_q[0].due < cyc) void'(exp_q.pop_front());
         exp_done = (exp_q.size() > 0) && (exp_q[0].due == cyc);
         chk("busy", busy, mdl_cnt != 0);
         chk("done", done, exp_done);
         if (exp_done) begin
            e        = exp_q.pop_front();
            held_v   = e.v;
            held_inv = e.inv;
            held_ovf = e.ovf;
         end
         chk("value", value, held_v);
         chk("invalid", invalid, held_inv);
         chk("overflow", overflow, held_ovf);
      end
   end

   task automatic run_start(input logic [AW-1:0] b);
      @(negedge clk);
      bcd_in = b;
      start  = 1'b1;
      @(negedge clk);
      start  = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (!busy && exp_q.size() == 0) return;
      end
      chk("timeout", 1'b1, 1'b0);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_busy"}, busy, 1'b0);
      chk({tag, "_done"}, done, 1'b0);
      chk({tag, "_value"}, value, '0);
      chk({tag, "_invalid"}, invalid, 1'b0);
      chk({tag, "_overflow"}, overflow, 1'b0);
   endtask

   initial begin
      logic [AW-1:0] r;
      checks   = 0;
      errors   = 0;
      cyc      = 0;
      mdl_cnt  = 0;
      held_v   = '0;
      held_inv = 1'b0;
      held_ovf = 1'b0;
      rst_n    = 1'b0;
      start    = 1'b0;
      bcd_in   = '0;
      repeat (3) @(negedge clk);
      #1;
      chk_zero("reset");
      @(negedge clk);
      #2 rst_n = 1'b1;

      // Directed operands, including range boundaries and a rejected operand.
      run_start(40'h0000000000); wait_idle();
      run_start(40'h0000001234); wait_idle();
      run_start(40'h1073741823); wait_idle();
      run_start(40'h1073741824); wait_idle();
      run_start(40'h9999999999); wait_idle();
      run_start(40'h00000A0005); wait_idle();
      run_start(40'h0000000009); wait_idle();

      // Random operands, occasionally with a non-decimal digit.
      for (int k = 0; k < 6; k++) begin
         for (int i = 0; i < N_DIGITS; i++) begin
            r[4*i +: 4] = 4'($urandom_range(0, 9));
         end
         if (k % 3 == 2) r[4*$urandom_range(0, N_DIGITS - 1) +: 4] = 4'($urandom_range(10, 15));
         run_start(r);
         wait_idle();
      end

      // Starts while busy are ignored; bcd_in changes while busy have no effect.
      run_start(40'h0000000321);
      repeat (3) @(negedge clk);
      bcd_in = 40'h0000005555;
      start  = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      repeat (14) @(negedge clk);
      bcd_in = 40'h00000A0A0A;
      start  = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      wait_idle();

      // Reset mid-conversion aborts immediately and leaves no done pulse.
      run_start(40'h0000987654);
      repeat (18) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk_zero("abort");
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      run_start(40'h0000000777); wait_idle();

      // Start held high: back-to-back conversions without an idle bubble.
      @(negedge clk);
      bcd_in = 40'h0000000042;
      start  = 1'b1;
      repeat (41 * 3 + 2) @(negedge clk);
      start  = 1'b0;
      wait_idle();

      // Rejected operand accepted in a done cycle overwrites the previous result.
      @(negedge clk);
      bcd_in = 40'h0000000050;
      start  = 1'b1;
      repeat (41) @(negedge clk);
      bcd_in = 40'hF000000000;
      @(negedge clk);
      start  = 1'b0;
      wait_idle();

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
